// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and helpers for the I2S stereo port.
// Default geometry is 64 BCLK per frame at 12.288 MHz (48 kHz).
package i2s_pkg;

  localparam int DEF_BCLK_DIV = 2;
  localparam int DEF_SLOT_W   = 32;
  localparam int DEF_SAMPLE_W = 24;

  localparam int CH_L = 0;
  localparam int CH_R = 1;

  // Never returns 0 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK/LRCLK generation from CLK with bit-slot tracking.
// rise_s/fall_s flag the CLK cycle that registers a bclk edge.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter  int BCLK_DIV = DEF_BCLK_DIV,
  parameter  int SLOT_W   = DEF_SLOT_W,
  localparam int BW       = clog2(SLOT_W)
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          bclk,
  output logic          lrclk,
  output logic          rise_s,
  output logic          fall_s,
  output logic [BW-1:0] bit_idx
);

  localparam int DW = clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] IDX_MAX = BW'(SLOT_W - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap   = (div_cnt == DIV_MAX);
  assign rise_s = wrap & ~bclk;
  assign fall_s = wrap & bclk;

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      bit_idx <= '0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) bclk <= ~bclk;
      if (fall_s) begin
        if (bit_idx == IDX_MAX) begin
          bit_idx <= '0;
          lrclk   <= ~lrclk;
        end else begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_stereo_port.sv
// i2s_stereo_port: I2S master, stereo capture with valid/ready outputs.
// Playback serialiser is built only when I2S_PLAYBACK_EN is defined.
module i2s_stereo_port
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = DEF_BCLK_DIV,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                rec_data,
  output logic                mclk,
  output logic                muten,
  output logic                bclk,
  output logic                lrclk,
  output logic [SAMPLE_W-1:0] left_data,
  output logic                left_valid,
  input  logic                left_ready,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                right_valid,
  input  logic                right_ready,
  output logic [1:0]          overrun,
  input  logic                overrun_clr,
  input  logic [SAMPLE_W-1:0] play_left_data,
  input  logic [SAMPLE_W-1:0] play_right_data,
  input  logic                play_left_valid,
  input  logic                play_right_valid,
  output logic                play_left_ready,
  output logic                play_right_ready,
  output logic                pbdata,
  output logic                pblrc,
  output logic [1:0]          underrun
);

  localparam int BW = clog2(SLOT_W);
  localparam logic [BW-1:0] IDX_LSB = BW'(SAMPLE_W);

  if (SAMPLE_W > SLOT_W - 1) begin : g_bad_width
    $error("SAMPLE_W must not exceed SLOT_W-1");
  end

  logic          rise_s;
  logic          fall_s;
  logic [BW-1:0] bit_idx;

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_W   (SLOT_W)
  ) u_clkgen (
    .CLK     (CLK),
    .RST     (RST),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .rise_s  (rise_s),
    .fall_s  (fall_s),
    .bit_idx (bit_idx)
  );

  assign mclk  = CLK;
  assign muten = 1'b1;
  assign pblrc = lrclk;

  logic [SAMPLE_W-1:0] cap_sh;
  logic                cap_done;
  logic                cap_ch;
  logic [1:0]          vld;
  logic [1:0]          rdy;
  logic [1:0]          load;
  logic [1:0]          xfer;
  logic [1:0]          ovr_set;
  logic [1:0]          ovr;

  assign rdy     = {right_ready, left_ready};
  assign load    = cap_done ? (cap_ch ? 2'b10 : 2'b01) : 2'b00;
  assign xfer    = vld & rdy;
  assign ovr_set = load & vld & ~rdy;

  assign left_valid  = vld[CH_L];
  assign right_valid = vld[CH_R];
  assign overrun     = ovr;

  // Slot bit 0 is the I2S one-bit delay; only 1..SAMPLE_W are data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_sh     <= '0;
      cap_done   <= 1'b0;
      cap_ch     <= 1'b0;
      vld        <= '0;
      ovr        <= '0;
      left_data  <= '0;
      right_data <= '0;
    end else begin
      cap_done <= rise_s && (bit_idx == IDX_LSB);
      cap_ch   <= lrclk;
      if (rise_s && bit_idx != '0 && bit_idx <= IDX_LSB)
        cap_sh <= {cap_sh[SAMPLE_W-2:0], rec_data};
      if (load[CH_L]) left_data  <= cap_sh;
      if (load[CH_R]) right_data <= cap_sh;
      vld <= load | (vld & ~xfer);
      ovr <= (overrun_clr ? 2'b00 : ovr) | ovr_set;
    end
  end

`ifdef I2S_PLAYBACK_EN
  localparam logic [BW-1:0] IDX_END = BW'(SLOT_W - 1);

  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic [SAMPLE_W-1:0] pb_sh;
  logic [1:0]          hfull;
  logic [1:0]          acc;
  logic [1:0]          mv;
  logic [1:0]          unr;
  logic                pb_q;
  logic                wrap_s;

  assign acc    = {play_right_valid, play_left_valid} & ~hfull;
  assign wrap_s = fall_s && (bit_idx == IDX_END);
  // lrclk is about to toggle, so the incoming slot is ~lrclk.
  assign mv     = wrap_s ? (lrclk ? 2'b01 : 2'b10) : 2'b00;

  assign play_left_ready  = ~hfull[CH_L];
  assign play_right_ready = ~hfull[CH_R];
  assign pbdata           = pb_q;
  assign underrun         = unr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_l <= '0;
      hold_r <= '0;
      pb_sh  <= '0;
      hfull  <= '0;
      unr    <= '0;
      pb_q   <= 1'b0;
    end else begin
      if (acc[CH_L]) hold_l <= play_left_data;
      if (acc[CH_R]) hold_r <= play_right_data;
      hfull <= acc | (hfull & ~mv);
      unr   <= (overrun_clr ? 2'b00 : unr) | (mv & ~hfull);
      if (mv[CH_L])
        pb_sh <= hfull[CH_L] ? hold_l : '0;
      else if (mv[CH_R])
        pb_sh <= hfull[CH_R] ? hold_r : '0;
      else if (fall_s && bit_idx < IDX_LSB)
        pb_sh <= pb_sh << 1;
      if (fall_s)
        pb_q <= (bit_idx < IDX_LSB) && pb_sh[SAMPLE_W-1];
    end
  end
`else
  logic unused_play;

  assign unused_play = ^{play_left_data, play_right_data,
                         play_left_valid, play_right_valid, fall_s};

  assign play_left_ready  = 1'b0;
  assign play_right_ready = 1'b0;
  assign pbdata           = 1'b0;
  assign underrun         = 2'b00;
`endif

endmodule

// File: tb/tb_i2s_stereo_port.sv
// tb_i2s_stereo_port: directed vectors for the I2S stereo port.
// Instance a uses defaults; instance b uses a 256-CLK frame.
module tb_i2s_stereo_port;

  localparam int DA = 2, SA = 32, WA = 24;
  localparam int DB = 4, SB = 16, WB = 15;
`ifdef I2S_PLAYBACK_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ovr_clr = 1'b0;

  logic          rec_a = 1'b0, mclk_a, muten_a, bclk_a, lrclk_a;
  logic [WA-1:0] ldat_a, rdat_a;
  logic          lval_a, rval_a;
  logic          lrdy_a = 1'b1, rrdy_a = 1'b1;
  logic [1:0]    ovr_a, unr_a;
  logic [WA-1:0] pld_a = '0, prd_a = '0;
  logic          plv_a = 1'b0, prv_a = 1'b0;
  logic          plr_a, prr_a, pbd_a, pblrc_a;

  logic          rec_b = 1'b0, mclk_b, muten_b, bclk_b, lrclk_b;
  logic [WB-1:0] ldat_b, rdat_b;
  logic          lval_b, rval_b;
  logic [1:0]    ovr_b, unr_b;
  logic          plr_b, prr_b, pbd_b, pblrc_b;

  logic [WA-1:0] slot_a [16];
  logic [WB-1:0] slot_b [4];

  int n = 0;
  int n_vec = 0;
  int n_err = 0;

  initial forever #5 CLK = ~CLK;

  i2s_stereo_port u_a (
    .CLK (CLK), .RST (RST), .rec_data (rec_a),
    .mclk (mclk_a), .muten (muten_a),
    .bclk (bclk_a), .lrclk (lrclk_a),
    .left_data (ldat_a), .left_valid (lval_a),
    .left_ready (lrdy_a),
    .right_data (rdat_a), .right_valid (rval_a),
    .right_ready (rrdy_a),
    .overrun (ovr_a), .overrun_clr (ovr_clr),
    .play_left_data (pld_a), .play_right_data (prd_a),
    .play_left_valid (plv_a), .play_right_valid (prv_a),
    .play_left_ready (plr_a), .play_right_ready (prr_a),
    .pbdata (pbd_a), .pblrc (pblrc_a), .underrun (unr_a)
  );

  i2s_stereo_port #(
    .BCLK_DIV (DB), .SLOT_W (SB), .SAMPLE_W (WB)
  ) u_b (
    .CLK (CLK), .RST (RST), .rec_data (rec_b),
    .mclk (mclk_b), .muten (muten_b),
    .bclk (bclk_b), .lrclk (lrclk_b),
    .left_data (ldat_b), .left_valid (lval_b),
    .left_ready (1'b1),
    .right_data (rdat_b), .right_valid (rval_b),
    .right_ready (1'b1),
    .overrun (ovr_b), .overrun_clr (ovr_clr),
    .play_left_data ('0), .play_right_data ('0),
    .play_left_valid (1'b0), .play_right_valid (1'b0),
    .play_left_ready (plr_b), .play_right_ready (prr_b),
    .pbdata (pbd_b), .pblrc (pblrc_b), .underrun (unr_b)
  );

  // CLK edges taken with RST low since the last reset.
  initial forever begin
    @(posedge CLK);
    n = RST ? 0 : n + 1;
  end

  // Codec model: bit k of the stream is presented until the next rise.
  initial forever begin
    int ka, pa, sa, kb, pb, sb;
    @(negedge CLK);
    ka = n / (2 * DA);
    pa = ka % SA;
    sa = (ka / SA) % 16;
    rec_a = (pa >= 1 && pa <= WA) ? slot_a[sa][WA-pa] : 1'b0;
    kb = n / (2 * DB);
    pb = kb % SB;
    sb = (kb / SB) % 4;
    rec_b = (pb >= 1 && pb <= WB) ? slot_b[sb][WB-pb] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int t);
    int guard;
    guard = 0;
    while (n < t && guard < 5000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (n < t) chk("timeout", n, t);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) slot_a[i] = '0;
    for (int i = 0; i < 4; i++) slot_b[i] = '0;
    slot_a[0]  = 24'hA5C3F1; slot_a[1] = 24'h123456;
    slot_a[2]  = 24'h000001; slot_a[3] = 24'h7FFFFF;
    slot_a[4]  = 24'h000002; slot_a[5] = 24'h800000;
    slot_a[6]  = 24'h000003; slot_a[7] = 24'h0F0F0F;
    slot_a[8]  = 24'h000004; slot_a[9] = 24'hABCDEF;
    slot_a[10] = 24'hFFFFFF;
    slot_b[0]  = 15'h4001;   slot_b[1] = 15'h3ABC;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_bclk", bclk_a, 0);
    chk("rst_lrclk", lrclk_a, 0);
    chk("rst_lval", lval_a, 0);
    chk("rst_rval", rval_a, 0);
    chk("rst_ldat", ldat_a, 0);
    chk("rst_ovr", ovr_a, 0);
    chk("rst_unr", unr_a, 0);
    chk("rst_pbd", pbd_a, 0);
    chk("rst_plr", plr_a, PB);
    chk("rst_prr", prr_a, PB);
    chk("mclk", mclk_a, 1);
    chk("muten", muten_a, 1);

    RST = 1'b0;
    pld_a = 24'h800001;
    plv_a = 1'b1;
    wait_n(1);
    plv_a = 1'b0;
    chk("pl_accept", plr_a, 0);
    chk("bclk_n1", bclk_a, 0);
    wait_n(2);  chk("bclk_n2", bclk_a, 1);
    wait_n(4);  chk("bclk_n4", bclk_a, 0);
                chk("bclkb_n4", bclk_b, 1);
    wait_n(8);  chk("bclkb_n8", bclk_b, 0);

    wait_n(98);  chk("l0_early", lval_a, 0);
    wait_n(99);  chk("l0_val", lval_a, 1);
                 chk("l0_dat", ldat_a, 24'hA5C3F1);
    wait_n(100); chk("l0_pulse", lval_a, 0);
    wait_n(124); chk("bl_early", lval_b, 0);
    wait_n(125); chk("bl_val", lval_b, 1);
                 chk("bl_dat", ldat_b, 15'h4001);
    wait_n(127); chk("lr_127", lrclk_a, 0);
                 chk("lrb_127", lrclk_b, 0);
    wait_n(128); chk("lr_128", lrclk_a, 1);
                 chk("lrb_128", lrclk_b, 1);
                 chk("pblrc", pblrc_a, 1);
                 chk("unr_r", unr_a, PB ? 2'b10 : 2'b00);
    wait_n(226); chk("r0_early", rval_a, 0);
    wait_n(227); chk("r0_val", rval_a, 1);
                 chk("r0_dat", rdat_a, 24'h123456);
    wait_n(228); chk("r0_pulse", rval_a, 0);
    lrdy_a = 1'b0;
    wait_n(253); chk("br_dat", rdat_b, 15'h3ABC);
                 chk("br_val", rval_b, 1);
    wait_n(256); chk("lr_256", lrclk_a, 0);
                 chk("pl_ready", plr_a, PB);
    wait_n(260); chk("pb_b1", pbd_a, PB);
    wait_n(264); chk("pb_b2", pbd_a, 0);
    wait_n(348); chk("pb_b23", pbd_a, 0);
    wait_n(352); chk("pb_b24", pbd_a, PB);
    wait_n(355); chk("l1_val", lval_a, 1);
                 chk("l1_dat", ldat_a, 24'h000001);
                 chk("l1_ovr", ovr_a, 0);
    wait_n(356); chk("pb_b25", pbd_a, 0);
    wait_n(388); chk("pb_rzero", pbd_a, 0);
                 chk("unr_hold", unr_a, PB ? 2'b10 : 2'b00);
    wait_n(483); chk("r1_dat", rdat_a, 24'h7FFFFF);
    wait_n(611); chk("l2_dat", ldat_a, 24'h000002);
                 chk("l2_ovr", ovr_a, 2'b01);
                 chk("l2_val", lval_a, 1);
    wait_n(739); chk("r2_dat", rdat_a, 24'h800000);

    wait_n(866);
    ovr_clr = 1'b1;
    wait_n(867);
    ovr_clr = 1'b0;
    chk("clr_set_ovr", ovr_a, 2'b01);
    chk("l3_dat", ldat_a, 24'h000003);
    chk("clr_unr", unr_a, 0);
    wait_n(870);
    ovr_clr = 1'b1;
    wait_n(871);
    ovr_clr = 1'b0;
    chk("clr_ovr", ovr_a, 0);

    wait_n(1122);
    lrdy_a = 1'b1;
    wait_n(1123); chk("l4_val", lval_a, 1);
                  chk("l4_dat", ldat_a, 24'h000004);
                  chk("l4_ovr", ovr_a, 0);
    wait_n(1124); chk("l4_pulse", lval_a, 0);

    wait_n(1328);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_lval", lval_a, 0);
    chk("mid_ldat", ldat_a, 0);
    chk("mid_lrclk", lrclk_a, 0);
    slot_a[0] = 24'h5A5A5A;
    slot_a[1] = 24'hC00003;
    RST = 1'b0;
    wait_n(50);  chk("re_lval50", lval_a, 0);
    wait_n(98);  chk("re_lval98", lval_a, 0);
    wait_n(99);  chk("re_lval", lval_a, 1);
                 chk("re_ldat", ldat_a, 24'h5A5A5A);
    wait_n(227); chk("re_rval", rval_a, 1);
                 chk("re_rdat", rdat_a, 24'hC00003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
